// File: rtl/kmeans_centroid_update_if.sv
// Sample/epoch handshake between the classifier side and the centroid updater.
// The master drives samples and epoch control; the slave returns the new centroid vector.
interface kmeans_centroid_update_if #(
    parameter int DW       = 16,
    parameter int CLUSTERS = 2,
    parameter int PARAMS   = 13,
    parameter int CLW      = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1
);
    logic                             clear_i;
    logic [PARAMS*DW-1:0]             data_i;
    logic [CLW-1:0]                   cluster_i;
    logic                             valid_i;
    logic                             ready_o;
    logic                             finish_i;
    logic [CLUSTERS*PARAMS*DW-1:0]    old_centroid_i;
    logic [CLUSTERS*PARAMS*DW-1:0]    centroid_o;
    logic                             centroid_valid_o;
    logic                             overflow_o;

    modport master (
        output clear_i, data_i, cluster_i, valid_i, finish_i, old_centroid_i,
        input  ready_o, centroid_o, centroid_valid_o, overflow_o
    );

    modport slave (
        input  clear_i, data_i, cluster_i, valid_i, finish_i, old_centroid_i,
        output ready_o, centroid_o, centroid_valid_o, overflow_o
    );
endinterface

// File: rtl/kmeans_centroid_update.sv
// Accumulates per-cluster feature sums and counts, then at epoch end divides every sum
// by its count with one shared restoring divider and publishes the new centroid vector.
module kmeans_centroid_update #(
    parameter int DW       = 16,
    parameter int CLUSTERS = 2,
    parameter int PARAMS   = 13,
    parameter int CNTW     = 16,
    parameter int CLW      = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1,
    parameter int AW       = DW + CNTW
) (
    input logic                     clk_i,
    input logic                     reset_i,
    kmeans_centroid_update_if.slave bus
);
    localparam int NE = CLUSTERS * PARAMS;
    localparam int PW = (PARAMS > 1) ? $clog2(PARAMS) : 1;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;
    localparam int SW = $clog2(AW + 1);

    typedef enum logic [1:0] {ACCUM, CALC, DONE} state_t;

    state_t              state;
    logic [AW-1:0]       sums   [CLUSTERS][PARAMS];
    logic [CNTW-1:0]     counts [CLUSTERS];
    logic [NE*DW-1:0]    shadow;

    logic [CLW-1:0]      c_idx;
    logic [PW-1:0]       p_idx;
    logic [EW-1:0]       elem;
    logic [SW-1:0]       step;
    logic [CNTW-1:0]     rem;
    logic [AW-1:0]       quo;
    logic [DW-1:0]       old_val;

    logic                in_range, full, accept, wipe;
    logic [CNTW-1:0]     divisor;
    logic [CNTW:0]       trial;
    logic                fits;
    logic [CNTW-1:0]     rem_next;
    logic [AW-1:0]       quo_next;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        in_range = int'(bus.cluster_i) < CLUSTERS;
        full     = in_range ? (counts[bus.cluster_i] == '1) : 1'b0;
        accept   = (state == ACCUM) && bus.valid_i && in_range && !full && !bus.clear_i;
        wipe     = bus.clear_i || (state == DONE);

        // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
        divisor  = counts[c_idx];
        trial    = {rem, quo[AW-1]};
        fits     = trial >= {1'b0, divisor};
        rem_next = fits ? CNTW'(trial - {1'b0, divisor}) : trial[CNTW-1:0];
        quo_next = {quo[AW-2:0], fits};
    end

    // NOTE: the sum/count arrays are real epoch state that must start at zero, so they are reset like any flop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < CLUSTERS; c++) begin
                counts[c] <= '0;
                for (int p = 0; p < PARAMS; p++) sums[c][p] <= '0;
            end
        end else if (wipe) begin
            for (int c = 0; c < CLUSTERS; c++) begin
                counts[c] <= '0;
                for (int p = 0; p < PARAMS; p++) sums[c][p] <= '0;
            end
        end else if (accept) begin
            counts[bus.cluster_i] <= counts[bus.cluster_i] + 1'b1;
            for (int p = 0; p < PARAMS; p++)
                sums[bus.cluster_i][p] <= sums[bus.cluster_i][p] + AW'(bus.data_i[p*DW +: DW]);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state                <= ACCUM;
            bus.ready_o          <= 1'b1;
            bus.centroid_o       <= '0;
            bus.centroid_valid_o <= 1'b0;
            bus.overflow_o       <= 1'b0;
            shadow               <= '0;
            c_idx                <= '0;
            p_idx                <= '0;
            elem                 <= '0;
            step                 <= '0;
            rem                  <= '0;
            quo                  <= '0;
            old_val              <= '0;
        end else begin
            bus.centroid_valid_o <= 1'b0;
            if (bus.clear_i) begin
                state          <= ACCUM;
                bus.ready_o    <= 1'b1;
                bus.overflow_o <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (bus.valid_i && full) bus.overflow_o <= 1'b1;
                        if (bus.finish_i) begin
                            state       <= CALC;
                            bus.ready_o <= 1'b0;
                            c_idx       <= '0;
                            p_idx       <= '0;
                            elem        <= '0;
                            step        <= '0;
                        end
                    end
                    CALC: begin
                        if (step == '0) begin
                            rem     <= '0;
                            quo     <= sums[c_idx][p_idx];
                            old_val <= bus.old_centroid_i[int'(elem)*DW +: DW];
                            step    <= step + 1'b1;
                        end else begin
                            rem <= rem_next;
                            quo <= quo_next;
                            if (step == SW'(AW)) begin
                                // Empty clusters keep the centroid they had at the start of this element.
                                shadow[int'(elem)*DW +: DW] <= (divisor == '0) ? old_val : quo_next[DW-1:0];
                                step <= '0;
                                elem <= elem + 1'b1;
                                if (p_idx == PW'(PARAMS - 1)) begin
                                    p_idx <= '0;
                                    if (c_idx == CLW'(CLUSTERS - 1)) begin
                                        c_idx <= '0;
                                        state <= DONE;
                                    end else begin
                                        c_idx <= c_idx + 1'b1;
                                    end
                                end else begin
                                    p_idx <= p_idx + 1'b1;
                                end
                            end else begin
                                step <= step + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        bus.centroid_o       <= shadow;
                        bus.centroid_valid_o <= 1'b1;
                        bus.ready_o          <= 1'b1;
                        state                <= ACCUM;
                    end
                    default: begin
                        state       <= ACCUM;
                        bus.ready_o <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Self-checking bench for kmeans_centroid_update: a default instance checked against an
// arithmetic mean model, plus a narrow-counter instance for saturation and full-scale data.
module tb_kmeans_centroid_update;
    localparam int DW    = 16;
    localparam int CL    = 2;
    localparam int PR    = 13;
    localparam int CNTW  = 16;
    localparam int CLW   = 1;
    localparam int NE    = CL * PR;
    localparam int VW    = NE * DW;
    localparam int SW_   = PR * DW;
    localparam int LAT   = NE * (DW + CNTW + 1) + 1;
    localparam int SCNTW = 2;
    localparam int SLAT  = NE * (DW + SCNTW + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kmeans_centroid_update_if #(.DW(DW), .CLUSTERS(CL), .PARAMS(PR)) bus ();
    kmeans_centroid_update_if #(.DW(DW), .CLUSTERS(CL), .PARAMS(PR)) bus_s ();

    kmeans_centroid_update #(.DW(DW), .CLUSTERS(CL), .PARAMS(PR), .CNTW(CNTW)) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus)
    );
    kmeans_centroid_update #(.DW(DW), .CLUSTERS(CL), .PARAMS(PR), .CNTW(SCNTW)) dut_s (
        .clk_i(clk), .reset_i(rst), .bus(bus_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    longint m_sum [CL][PR];
    longint m_cnt [CL];

    function automatic logic [SW_-1:0] splat(input logic [DW-1:0] v);
        logic [SW_-1:0] r;
        for (int p = 0; p < PR; p++) r[p*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [SW_-1:0] rand_sample();
        logic [SW_-1:0] r;
        for (int p = 0; p < PR; p++) r[p*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_centroids();
        logic [VW-1:0] r;
        for (int e = 0; e < NE; e++) r[e*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < CL; c++) begin
            m_cnt[c] = 0;
            for (int p = 0; p < PR; p++) m_sum[c][p] = 0;
        end
    endfunction

    function automatic void model_accept(input logic [SW_-1:0] d, input int cl);
        if (cl < CL && m_cnt[cl] < (64'd1 << CNTW) - 1) begin
            m_cnt[cl] = m_cnt[cl] + 1;
            for (int p = 0; p < PR; p++) m_sum[cl][p] = m_sum[cl][p] + longint'(d[p*DW +: DW]);
        end
    endfunction

    // Mean per (cluster, feature); an empty cluster falls back to the supplied old centroid.
    function automatic logic [VW-1:0] model_result(input logic [VW-1:0] old);
        logic [VW-1:0] r;
        for (int c = 0; c < CL; c++)
            for (int p = 0; p < PR; p++)
                r[(c*PR+p)*DW +: DW] = (m_cnt[c] == 0) ? old[(c*PR+p)*DW +: DW]
                                                       : DW'(m_sum[c][p] / m_cnt[c]);
        return r;
    endfunction

    task automatic drive(input bit v, input logic [SW_-1:0] d, input int cl, input bit fin);
        logic rdy;
        rdy           = bus.ready_o;
        bus.valid_i   = v;
        bus.data_i    = d;
        bus.cluster_i = CLW'(cl);
        bus.finish_i  = fin;
        @(posedge clk); #1;
        if (v && rdy) model_accept(d, cl);
        bus.valid_i  = 1'b0;
        bus.finish_i = 1'b0;
    endtask

    task automatic drive_s(input logic [SW_-1:0] d, input int cl, input bit v, input bit fin);
        bus_s.valid_i   = v;
        bus_s.data_i    = d;
        bus_s.cluster_i = CLW'(cl);
        bus_s.finish_i  = fin;
        @(posedge clk); #1;
        bus_s.valid_i  = 1'b0;
        bus_s.finish_i = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.centroid_valid_o && n < limit);
    endtask

    task automatic test_reset();
        bus.clear_i = 0; bus.valid_i = 0; bus.finish_i = 0; bus.data_i = '0;
        bus.cluster_i = '0; bus.old_centroid_i = '0;
        bus_s.clear_i = 0; bus_s.valid_i = 0; bus_s.finish_i = 0; bus_s.data_i = '0;
        bus_s.cluster_i = '0; bus_s.old_centroid_i = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.centroid_o !== '0) begin n_err++; $display("FAIL reset_centroid got %h want 0", bus.centroid_o); end
        n_cmp++; if (bus.centroid_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.centroid_valid_o); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", bus.overflow_o); end
    endtask

    task automatic test_basic();
        logic [VW-1:0] exp;
        int n;
        bus.old_centroid_i = rand_centroids();
        drive(1, splat(16'd10), 0, 0);
        drive(1, splat(16'd20), 0, 0);
        drive(1, splat(16'd7), 1, 0);
        drive(0, '0, 0, 1);
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready_calc got %b want 0", bus.ready_o); end
        exp = {splat(16'd7), splat(16'd15)};
        wait_pulse(LAT + 50, n);
        n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL basic_latency got %0d want %0d", n, LAT); end
        n_cmp++; if (bus.centroid_o !== exp) begin n_err++; $display("FAIL basic_result got %h want %h", bus.centroid_o, exp); end
        @(posedge clk); #1;
        n_cmp++; if (bus.centroid_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width got %b want 0", bus.centroid_valid_o); end
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready_after got %b want 1", bus.ready_o); end
        model_clear();
    endtask

    task automatic test_empty_cluster();
        logic [VW-1:0] old, exp;
        int n;
        old = {splat(16'd100), rand_sample()};
        bus.old_centroid_i = old;
        drive(1, splat(16'd4), 0, 0);
        drive(1, splat(16'd4), 0, 0);
        drive(0, '0, 0, 1);
        exp = {splat(16'd100), splat(16'd4)};
        wait_pulse(LAT + 50, n);
        n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL empty_latency got %0d want %0d", n, LAT); end
        n_cmp++; if (bus.centroid_o !== exp) begin n_err++; $display("FAIL empty_result got %h want %h", bus.centroid_o, exp); end
        model_clear();
    endtask

    task automatic test_trunc_finish();
        logic [VW-1:0] old, exp;
        int n;
        old = rand_centroids();
        bus.old_centroid_i = old;
        drive(1, splat(16'd1), 0, 0);
        drive(1, splat(16'd2), 0, 0);
        drive(1, splat(16'd3), 0, 1);
        // Samples and finish presented during CALC must be ignored.
        drive(1, splat(16'd1000), 1, 1);
        drive(1, splat(16'd1000), 0, 0);
        exp = {old[VW-1:SW_], splat(16'd2)};
        n_cmp++; if (model_result(old) !== exp) begin n_err++; $display("FAIL trunc_model got %h want %h", model_result(old), exp); end
        wait_pulse(LAT + 50, n);
        n_cmp++; if (n !== LAT - 2) begin n_err++; $display("FAIL trunc_latency got %0d want %0d", n, LAT - 2); end
        n_cmp++; if (bus.centroid_o !== exp) begin n_err++; $display("FAIL trunc_result got %h want %h", bus.centroid_o, exp); end
        model_clear();
    endtask

    task automatic test_clear();
        logic [VW-1:0] prev, old, exp;
        int pulses, n;
        prev = bus.centroid_o;
        bus.old_centroid_i = rand_centroids();
        drive(1, splat(16'd50), 0, 0);
        drive(1, splat(16'd60), 1, 0);
        drive(0, '0, 0, 1);
        repeat (299) @(posedge clk);
        #1 bus.clear_i = 1'b1;
        @(posedge clk); #1;
        bus.clear_i = 1'b0;
        model_clear();
        n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL clear_ready got %b want 1", bus.ready_o); end
        pulses = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(posedge clk); #1;
            if (bus.centroid_valid_o) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL clear_no_pulse got %0d want 0", pulses); end
        n_cmp++; if (bus.centroid_o !== prev) begin n_err++; $display("FAIL clear_hold got %h want %h", bus.centroid_o, prev); end
        // Only post-clear samples may contribute; cluster0 must come back empty.
        old = rand_centroids();
        bus.old_centroid_i = old;
        drive(1, splat(16'd9), 1, 1);
        exp = {splat(16'd9), old[SW_-1:0]};
        wait_pulse(LAT + 50, n);
        n_cmp++; if (bus.centroid_o !== exp) begin n_err++; $display("FAIL clear_counts_zero got %h want %h", bus.centroid_o, exp); end
        model_clear();
    endtask

    task automatic test_random();
        logic [VW-1:0] old, exp;
        int n, ns;
        for (int ep = 0; ep < 4; ep++) begin
            old = rand_centroids();
            bus.old_centroid_i = old;
            ns = $urandom_range(1, 24);
            for (int s = 0; s < ns; s++)
                drive(1, rand_sample(), (ep == 2) ? 1 : $urandom_range(0, CL - 1), (s == ns - 1) && ep[0]);
            if (!ep[0]) drive(0, '0, 0, 1);
            exp = model_result(old);
            wait_pulse(LAT + 50, n);
            n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL random_latency ep%0d got %0d want %0d", ep, n, LAT); end
            n_cmp++; if (bus.centroid_o !== exp) begin n_err++; $display("FAIL random_result ep%0d got %h want %h", ep, bus.centroid_o, exp); end
            model_clear();
        end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] old, exp;
        int n;
        old = {splat(16'h1234), splat(16'h0abc)};
        bus_s.old_centroid_i = old;
        for (int i = 0; i < 3; i++) drive_s(splat(16'd8), 0, 1, 0);
        n_cmp++; if (bus_s.overflow_o !== 1'b0) begin n_err++; $display("FAIL sat_no_overflow got %b want 0", bus_s.overflow_o); end
        drive_s(splat(16'd8), 0, 1, 0);
        n_cmp++; if (bus_s.overflow_o !== 1'b1) begin n_err++; $display("FAIL sat_overflow got %b want 1", bus_s.overflow_o); end
        drive_s('0, 0, 0, 1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus_s.centroid_valid_o && n < SLAT + 50);
        exp = {splat(16'h1234), splat(16'd8)};
        n_cmp++; if (n !== SLAT) begin n_err++; $display("FAIL sat_latency got %0d want %0d", n, SLAT); end
        n_cmp++; if (bus_s.centroid_o !== exp) begin n_err++; $display("FAIL sat_result got %h want %h", bus_s.centroid_o, exp); end
        n_cmp++; if (bus_s.overflow_o !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %b want 1", bus_s.overflow_o); end
        for (int i = 0; i < 3; i++) drive_s(splat(16'hffff), 1, 1, i == 2);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus_s.centroid_valid_o && n < SLAT + 50);
        exp = {splat(16'hffff), splat(16'h0abc)};
        n_cmp++; if (bus_s.centroid_o !== exp) begin n_err++; $display("FAIL sat_fullscale got %h want %h", bus_s.centroid_o, exp); end
        #1 bus_s.clear_i = 1'b1;
        @(posedge clk); #1;
        bus_s.clear_i = 1'b0;
        n_cmp++; if (bus_s.overflow_o !== 1'b0) begin n_err++; $display("FAIL sat_clear_overflow got %b want 0", bus_s.overflow_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_cluster();
        test_trunc_finish();
        test_clear();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
